// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus controller: address regions,
// FSM state encoding and the region decode helper.
package mio_pkg;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_GPIO = 4'hE;
  localparam logic [3:0] REG_CNT  = 4'hF;

  // Wide enough for RAM_LAT-1 with RAM_LAT up to 7.
  localparam int WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESP     = 2'd2
  } mio_state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_GPIO,
    RGN_CNT,
    RGN_NONE
  } mio_region_e;

  function automatic mio_region_e decode_region(input logic [3:0] top_nibble);
    case (top_nibble)
      REG_RAM:  return RGN_RAM;
      REG_GPIO: return RGN_GPIO;
      REG_CNT:  return RGN_CNT;
      default:  return RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Load/decrement counter: free-running down-count that parks at zero,
// with a load that takes priority over the decrement.
module mio_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt
);

  // Load wins; otherwise count down and hold at zero without wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller sitting behind the multi-cycle CPU. Decodes the
// CPU request onto on-chip RAM, GPIO or the counter and returns a one-cycle
// MIO_ready with read data on Data_in.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for CPU_MIO; accepts and launches the access
// RAM_WAIT | RAM access in flight, wait counter running down to zero
// RESP     | MIO_ready high for this single cycle, then back to IDLE
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw_in,
  output logic [SW_W-1:0]   led_out,
  output logic [31:0]       cnt_out,
  output logic              bus_err
);

  mio_state_e        state, state_nxt;
  mio_region_e       rgn;
  logic              accept;
  logic              req_we;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cnt_ld;

  // Only the region nibble and the RAM word-address bits take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr_out[27:RAM_AW+2], Addr_out[1:0]};

  assign rgn    = decode_region(Addr_out[31:28]);
  assign cnt_ld = accept && (rgn == RGN_CNT) && mem_w;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; CPU_MIO is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (CPU_MIO) begin
          accept    = 1'b1;
          state_nxt = (rgn == RGN_RAM) ? RAM_WAIT : RESP;
        end
      end
      RAM_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, RAM strobes, IO side effects, read data and ready pulse.
  // The wait count includes the ram_en cycle itself, so a read captures
  // ram_dout RAM_LAT cycles after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Data_in   <= '0;
      MIO_ready <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      led_out   <= '0;
      bus_err   <= 1'b0;
      req_we    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      // RESP is always left after one cycle, so this is a single-cycle pulse.
      MIO_ready <= (state_nxt == RESP);
      if (accept) begin
        req_we <= mem_w;
        case (rgn)
          RGN_RAM: begin
            ram_en   <= 1'b1;
            ram_we   <= mem_w;
            ram_addr <= Addr_out[RAM_AW+1:2];
            ram_din  <= Data_out;
            wait_cnt <= mem_w ? '0 : WAIT_W'(RAM_LAT - 1);
          end
          RGN_GPIO: begin
            if (mem_w) begin
              led_out <= Data_out[SW_W-1:0];
            end else begin
              Data_in <= 32'(sw_in);
            end
          end
          RGN_CNT: begin
            if (!mem_w) begin
              Data_in <= cnt_out;
            end
          end
          default: begin
            bus_err <= 1'b1;
            if (!mem_w) begin
              Data_in <= '0;
            end
          end
        endcase
      end else if (state == RAM_WAIT) begin
        if (wait_cnt == '0) begin
          if (!req_we) begin
            Data_in <= ram_dout;
          end
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
    end
  end

  mio_counter #(
    .W(32)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .ld     (cnt_ld),
    .ld_val (Data_out),
    .cnt    (cnt_out)
  );

endmodule
